fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 154 +++++++++++++++
 tb/tb_fetch_stage.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction fetch stage: WAIT/FETCH/HOLD sequencing of a single-word instruction
// memory, one-slot redirect buffering, IF/ID handoff. Optional feature: IF_MISALIGN_CHECK_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc8_if,
    output logic [31:0] instr_if,
    output logic        if_valid,
`ifdef IF_MISALIGN_CHECK_EN
    output logic        misalign,
`endif
    output logic        ifid_ena
);

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      state, next_state;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        pend_vld;
    logic [31:0] pend_pc;
    logic [31:0] instr_buf;
    logic        advance;
    logic        capture;
    logic        misalign_int;

    assign imem_addr = {pc[31:2], 2'b00};
    assign pc8_if    = pc + 32'd8;

    // A redirect seen in the same cycle wins over an older pending one.
    always_comb begin
        if (redirect) begin
            next_pc = redirect_pc;
        end else if (pend_vld) begin
            next_pc = pend_pc;
        end else begin
            next_pc = pc + 32'd4;
        end
    end

    always_comb begin
        next_state   = state;
        imem_req     = 1'b0;
        instr_if     = 32'd0;
        if_valid     = 1'b0;
        ifid_ena     = 1'b0;
        advance      = 1'b0;
        capture      = 1'b0;
        misalign_int = 1'b0;

        case (state)
            S_WAIT: begin
                next_state = S_FETCH;
            end

            S_FETCH: begin
`ifdef IF_MISALIGN_CHECK_EN
                if (pc[1:0] != 2'b00) begin
                    // Misaligned pc: no memory access, a bubble goes down and pc still advances.
                    misalign_int = !stall;
                    ifid_ena     = !stall;
                    advance      = !stall;
                end else
`endif
                begin
                    imem_req = 1'b1;
                    if (imem_rdy) begin
                        if (!stall) begin
                            instr_if = imem_rdata;
                            if_valid = 1'b1;
                            ifid_ena = 1'b1;
                            advance  = 1'b1;
                        end else begin
                            capture    = 1'b1;
                            next_state = S_HOLD;
                        end
                    end else begin
                        ifid_ena = !stall;
                    end
                end
            end

            S_HOLD: begin
                if (!stall) begin
                    instr_if   = instr_buf;
                    if_valid   = 1'b1;
                    ifid_ena   = 1'b1;
                    advance    = 1'b1;
                    next_state = S_FETCH;
                end
            end

            default: begin
                next_state = S_WAIT;
            end
        endcase

        if (!rst) begin
            next_state   = S_WAIT;
            imem_req     = 1'b0;
            instr_if     = 32'd0;
            if_valid     = 1'b0;
            ifid_ena     = 1'b0;
            advance      = 1'b0;
            capture      = 1'b0;
            misalign_int = 1'b0;
        end
    end

`ifdef IF_MISALIGN_CHECK_EN
    assign misalign = misalign_int;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_WAIT;
            pc        <= RESET_PC;
            pend_vld  <= 1'b0;
            instr_buf <= 32'd0;
        end else begin
            state <= next_state;
            if (advance) begin
                pc       <= next_pc;
                pend_vld <= 1'b0;
            end else if (redirect) begin
                pend_vld <= 1'b1;
            end
            if (capture) begin
                instr_buf <= imem_rdata;
            end
        end
    end

    // Target address is data only; its validity is carried by pend_vld.
    always_ff @(posedge clk) begin
        if (!advance && redirect) begin
            pend_pc <= redirect_pc;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset, streaming, stall/HOLD, redirects, reset in HOLD, wrap.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rdy;
    logic [31:0] imem_rdata;
    logic [31:0] pc8_if;
    logic [31:0] instr_if;
    logic        if_valid;
    logic        ifid_ena;
`ifdef IF_MISALIGN_CHECK_EN
    logic        misalign;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    fetch_stage dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdy    (imem_rdy),
        .imem_rdata  (imem_rdata),
        .pc8_if      (pc8_if),
        .instr_if    (instr_if),
        .if_valid    (if_valid),
`ifdef IF_MISALIGN_CHECK_EN
        .misalign    (misalign),
`endif
        .ifid_ena    (ifid_ena)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory word encodes its own address so delivered instructions are identifiable.
    assign imem_rdata = {8'hC0, imem_addr[23:0]};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs sampled 1 ns later.
    task automatic cyc(input logic r, input logic s, input logic rd, input logic red,
                       input logic [31:0] rpc);
        @(negedge clk);
        rst = r; stall = s; imem_rdy = rd; redirect = red; redirect_pc = rpc;
        #1;
    endtask

    task automatic chk_out(input string tag, input logic req, input logic [31:0] addr,
                           input logic [31:0] instr, input logic vld, input logic ena);
        chk({tag, ".req"},   {31'd0, imem_req}, {31'd0, req});
        chk({tag, ".addr"},  imem_addr, addr);
        chk({tag, ".instr"}, instr_if, instr);
        chk({tag, ".vld"},   {31'd0, if_valid}, {31'd0, vld});
        chk({tag, ".ena"},   {31'd0, ifid_ena}, {31'd0, ena});
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; imem_rdy = 1'b1; redirect = 1'b0; redirect_pc = 32'd0;

        // Reset held
        cyc(0, 0, 1, 0, 0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_vld", {31'd0, if_valid}, 32'd0);
        chk("rst_ena", {31'd0, ifid_ena}, 32'd0);
        chk("rst_instr", instr_if, 32'd0);
        chk("rst_pc8", pc8_if, 32'd8);

        // Release: WAIT cycle, then 0,4,8 stream
        cyc(1, 0, 1, 0, 0);
        chk("wait_req", {31'd0, imem_req}, 32'd0);
        chk("wait_ena", {31'd0, ifid_ena}, 32'd0);
        cyc(1, 0, 1, 0, 0);
        chk_out("f0", 1, 32'h0, 32'hC000_0000, 1, 1);
        chk("f0_pc8", pc8_if, 32'd8);
        cyc(1, 0, 1, 0, 0);
        chk_out("f4", 1, 32'h4, 32'hC000_0004, 1, 1);
        chk("f4_pc8", pc8_if, 32'd12);
        cyc(1, 0, 1, 0, 0);
        chk_out("f8", 1, 32'h8, 32'hC000_0008, 1, 1);
        chk("f8_pc8", pc8_if, 32'd16);
        cyc(1, 0, 1, 0, 0);
        chk("fc_addr", imem_addr, 32'hC);

        // Stall with data ready at 0x10 -> HOLD for 3 cycles
        cyc(1, 1, 1, 0, 0);
        chk_out("st0", 1, 32'h10, 32'h0, 0, 0);
        cyc(1, 1, 1, 0, 0);
        chk_out("hold1", 0, 32'h10, 32'h0, 0, 0);
        cyc(1, 1, 1, 0, 0);
        chk_out("hold2", 0, 32'h10, 32'h0, 0, 0);
        cyc(1, 0, 1, 0, 0);
        chk_out("hold_rel", 0, 32'h10, 32'hC000_0010, 1, 1);
        cyc(1, 0, 1, 0, 0);
        chk_out("f14", 1, 32'h14, 32'hC000_0014, 1, 1);
        cyc(1, 0, 1, 0, 0);
        chk("f18_addr", imem_addr, 32'h18);
        cyc(1, 0, 1, 0, 0);
        chk("f1c_addr", imem_addr, 32'h1C);

        // Redirect on a delivery at 0x20
        cyc(1, 0, 1, 1, 32'h100);
        chk_out("br20", 1, 32'h20, 32'hC000_0020, 1, 1);
        cyc(1, 0, 1, 1, 32'h40);
        chk_out("t100", 1, 32'h100, 32'hC000_0100, 1, 1);

        // Redirect during a bubble at 0x40 is held until 0x40 is delivered
        cyc(1, 0, 0, 1, 32'h200);
        chk_out("bub40", 1, 32'h40, 32'h0, 0, 1);
        cyc(1, 0, 1, 0, 0);
        chk_out("dly40", 1, 32'h40, 32'hC000_0040, 1, 1);
        cyc(1, 0, 1, 0, 0);
        chk_out("t200", 1, 32'h200, 32'hC000_0200, 1, 1);

        // Enter HOLD with a pending redirect, then reset
        cyc(1, 1, 1, 1, 32'h200);
        chk_out("st204", 1, 32'h204, 32'h0, 0, 0);
        cyc(0, 1, 1, 0, 0);
        chk_out("rst_hold", 0, 32'h204, 32'h0, 0, 0);
        cyc(1, 0, 1, 0, 0);
        chk_out("rwait", 0, 32'h0, 32'h0, 0, 0);
        cyc(1, 0, 1, 1, 32'hFFFF_FFFC);
        chk_out("r0", 1, 32'h0, 32'hC000_0000, 1, 1);

        // Address wrap at the top of memory
        cyc(1, 0, 1, 0, 0);
        chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        chk("wrap_pc8", pc8_if, 32'h4);
        cyc(1, 1, 0, 0, 0);
        chk_out("wrap0_stall", 1, 32'h0, 32'h0, 0, 0);
        cyc(1, 0, 1, 0, 0);
        chk_out("wrap0", 1, 32'h0, 32'hC000_0000, 1, 1);

`ifdef IF_MISALIGN_CHECK_EN
        // pc is 0x4 now; redirect to a misaligned target
        cyc(1, 0, 1, 1, 32'h102);
        chk("ma_pre", {31'd0, misalign}, 32'd0);
        cyc(1, 0, 1, 0, 0);
        chk("ma_flag", {31'd0, misalign}, 32'd1);
        chk("ma_req", {31'd0, imem_req}, 32'd0);
        chk("ma_instr", instr_if, 32'd0);
        chk("ma_vld", {31'd0, if_valid}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
